// File: rtl/filter_select_ctrl.sv
// filter_select_ctrl: synchronizes, debounces and frame-aligns the filter-select switches
//   clk, reset   : 50 MHz clock, asynchronous active-high reset
//   sw_raw       : raw slide switches (asynchronous)
//   frame_start  : one-cycle pulse at start of vertical blanking
//   filter_sel   : committed select (one-hot filter, 0 pass-through, multi-hot invalid)
//   sel_valid    : committed select has at most one bit set
//   pending      : debounced select waiting for frame_start
//   sel_changed  : one-cycle pulse when filter_sel is (re)loaded
module filter_select_ctrl #(
  parameter int N_SW = 5,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_SW-1:0] sw_raw,
  input  logic            frame_start,
  output logic [N_SW-1:0] filter_sel,
  output logic            sel_valid,
  output logic            pending,
  output logic            sel_changed
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  typedef enum logic {IDLE, PENDING} state_t;
  state_t state_q, state_d;
  logic [N_SW-1:0] sync1_q, sync2_q, cand_q, stable_q, pend_sel_q, filter_sel_q;
  logic [N_SW-1:0] cand_d, stable_d, pend_sel_d, filter_sel_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic sel_valid_q, sel_valid_d, sel_changed_q, sel_changed_d;
  logic upd, commit;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      cand_q <= '0;
      stable_q <= '0;
      cnt_q <= '0;
      pend_sel_q <= '0;
      state_q <= IDLE;
      filter_sel_q <= '0;
      sel_valid_q <= 1'b1;
      sel_changed_q <= 1'b0;
    end else begin
      sync1_q <= sw_raw;
      sync2_q <= sync1_q;
      cand_q <= cand_d;
      stable_q <= stable_d;
      cnt_q <= cnt_d;
      pend_sel_q <= pend_sel_d;
      state_q <= state_d;
      filter_sel_q <= filter_sel_d;
      sel_valid_q <= sel_valid_d;
      sel_changed_q <= sel_changed_d;
    end
  end
  always_comb begin
    upd = (sync2_q == cand_q) && (cand_q != stable_q) && (cnt_q == CNT_MAX);
    commit = (state_q == PENDING) && frame_start;
    // cand always tracks sync2; any difference restarts the count
    cand_d = sync2_q;
    cnt_d = (sync2_q != cand_q || cand_q == stable_q || upd) ? '0 : cnt_q + CW'(1);
    stable_d = upd ? cand_q : stable_q;
    pend_sel_d = upd ? cand_q : pend_sel_q;
    // a stable update coinciding with a commit keeps the FSM pending for the new value
    state_d = upd ? PENDING : (commit ? IDLE : state_q);
    filter_sel_d = commit ? pend_sel_q : filter_sel_q;
    sel_valid_d = commit ? ((pend_sel_q & (pend_sel_q - N_SW'(1))) == '0) : sel_valid_q;
    sel_changed_d = commit;
  end
  assign filter_sel = filter_sel_q;
  assign sel_valid = sel_valid_q;
  assign pending = (state_q == PENDING);
  assign sel_changed = sel_changed_q;
endmodule

// File: doc/filter_select_ctrl.md
Name: filter_select_ctrl

Overview:
Upstream stage of the filter-status LED decoder and of the video filter pipeline. It conditions the 5 raw filter-select slide switches: a 2-flop synchronizer, then a debouncer. It holds a debounced change as pending and commits it only on a frame boundary, so a filter never switches mid-frame. The committed 5-bit one-hot select (zero = pass-through) drives both the LED colour decoder and the filter datapath.

Parameters:
N_SW, 5, number of select switches; width of every select bus.
DEBOUNCE_CYCLES, 500000, consecutive stable cycles required before a switch pattern is accepted (10 ms at 50 MHz); legal range ≥2.

Ports:
clk  in  1  system clock (50 MHz).
reset  in  1  asynchronous, active-high reset.
sw_raw  in  N_SW  raw slide switches, asynchronous to clk.
frame_start  in  1  single-cycle pulse from video timing at start of vertical blanking.
filter_sel  out  N_SW  committed filter select. One-hot = filter; 0 = pass-through; multi-hot = invalid, passed through as-is.
sel_valid  out  1  registered; 1 when committed filter_sel has popcount ≤1.
pending  out  1  debounced selection is waiting for frame_start.
sel_changed  out  1  1-cycle pulse in the cycle filter_sel takes a new value.

Behaviour:
- Clocking/reset: one clock domain. Reset is asynchronous and active-high. All flops clear on reset assertion, with no wait for clk.
- Reset values: sync1, sync2, cand, stable, pend_sel and filter_sel = 0. cnt = 0. pending = 0. sel_changed = 0. sel_valid = 1.
- Synchronizer: sync1 <= sw_raw; sync2 <= sync1. No logic between the two flops.
- Debounce: counter width is the localparam $clog2(DEBOUNCE_CYCLES).
  - If sync2 != cand: cand <= sync2, cnt <= 0.
  - Else if cand != stable and cnt == DEBOUNCE_CYCLES-1: stable <= cand, cnt <= 0.
  - Else if cand != stable: cnt <= cnt+1.
  - Else: cnt <= 0.
  - Any bounce restarts the count. A bounce that returns to the stable value cancels the pending acceptance.
- Latency: raw change held steady → stable updates exactly DEBOUNCE_CYCLES+2 cycles after the first clk edge that samples it into sync1.
- Pending: on the cycle stable updates, pend_sel <= new stable value and pending <= 1. A later stable update before commit overwrites pend_sel (last value wins).
- States: IDLE (pending=0) and PENDING (pending=1).
  - IDLE→PENDING on stable update.
  - PENDING→IDLE on frame_start. In that cycle: filter_sel <= pend_sel, sel_valid <= (popcount(pend_sel) ≤ 1), sel_changed <= 1.
  - sel_changed is 0 in every other cycle.
- frame_start in IDLE: no effect; outputs hold.
- Simultaneous stable update and frame_start:
  - Commit uses pend_sel as held before the edge.
  - pend_sel loads the new stable value; pending stays 1.
  - The new value commits at the next frame_start.
- Committing a value equal to the current filter_sel still pulses sel_changed.
- frame_start asserted on consecutive cycles: each cycle is evaluated independently per the rules above.
- Reset mid-operation: pending selection is discarded. filter_sel returns to 0 (pass-through) immediately. Debounce restarts from 0.

Test Plan:
- Reset: assert reset mid-cycle with filter_sel=5'b00100, pending=1 → all outputs 0 and sel_valid=1 asynchronously, before the next clk edge.
- Clean change (DEBOUNCE_CYCLES=4): sw_raw 0→5'b00010 held → pending rises 6 cycles after the first sampling edge; filter_sel stays 0. frame_start → filter_sel=5'b00010, sel_changed 1 cycle, pending=0, sel_valid=1.
- Bounce: sw_raw toggles 5'b00001/0 every 2 cycles for 20 cycles, then settles at 5'b00001 → no stable update during toggling; pending rises 6 cycles after settling.
- Last-wins: debounce 5'b01000, then 5'b10000, before any frame_start → single frame_start commits 5'b10000; exactly one sel_changed pulse.
- Collision: frame_start in the same cycle stable updates to 5'b00100, with pend_sel=5'b00010 → filter_sel=5'b00010, pending stays 1. Next frame_start → filter_sel=5'b00100.
- Invalid: debounce and commit 5'b00011 → filter_sel=5'b00011, sel_valid=0. frame_start with pending=0 → no change, sel_changed stays 0.
